acc64_sequencer: RTL and testbench

- Sequences the shared 64-bit signed adder to accumulate a fixed-length burst of signed 64-bit terms into one sum.
- Typical source of terms: filter-tap products in the noise-cancelling datapath.
- Sits between the product stream (valid/ready) and the coefficient/update logic that consumes the finished sum (valid/ready).
- Owns the adder operand mux. The adder itself stays a separate combinational instance driven through add_a/add_b/add_sum.

---
 rtl/acc64_sequencer_if.sv | 44 ++++
 rtl/acc64_sequencer.sv | 129 ++++++++++++
 tb/tb_acc64_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc64_sequencer_if.sv
// acc64_sequencer_if
// Bundles the term stream, the burst-sum stream and the shared adder operand
// bus of the 64-bit accumulation sequencer.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds data stable
// while valid=1 and ready=0. The consumer may raise or drop ready freely.
//
// Signals:
//   start      burst start request (level)          environment -> sequencer
//   in_valid   term available on in_data            environment -> sequencer
//   in_data    signed 64-bit term                   environment -> sequencer
//   in_ready   sequencer accepts a term             sequencer   -> environment
//   out_valid  burst sum available                  sequencer   -> environment
//   out_data   signed 64-bit burst sum              sequencer   -> environment
//   out_ready  consumer accepts out_data            environment -> sequencer
//   add_a      adder operand A (accumulator)        sequencer   -> adder
//   add_b      adder operand B (term or zero)       sequencer   -> adder
//   add_sum    add_a + add_b modulo 2^64            adder       -> sequencer
//
// The slave modport is the sequencer's view. The master modport is the view
// of the surrounding logic, which also hosts the adder.
interface acc64_sequencer_if;
  logic        start;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [63:0] add_sum;

  modport slave (
    input  start, in_valid, in_data, out_ready, add_sum,
    output in_ready, out_valid, out_data, add_a, add_b
  );

  modport master (
    output start, in_valid, in_data, out_ready, add_sum,
    input  in_ready, out_valid, out_data, add_a, add_b
  );
endinterface

// File: rtl/acc64_sequencer.sv
// acc64_sequencer
// Accumulates a burst of N_TERMS signed 64-bit terms into a single sum. It
// uses an external combinational 64-bit adder, driving its operands and taking
// back its result.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        synchronous active-high reset
//   bus        acc64_sequencer_if.slave: start, term stream, sum stream, adder bus
//   busy       high while accumulating or holding a finished sum
//   ovf        sticky signed overflow flag of the current or last burst
//   term_cnt   terms accepted so far in the current burst
//   dbg_state  current FSM state (0 IDLE, 1 ACCUM, 2 DONE)
//
// States: IDLE waits for start. ACCUM takes one term per input transfer. DONE
// presents the sum until it is taken. The previous sum and ovf stay readable
// in IDLE until the next start clears them.
module acc64_sequencer #(
  parameter int N_TERMS = 32,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  acc64_sequencer_if.slave bus,
  output logic             busy,
  output logic             ovf,
  output logic [CNT_W-1:0] term_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [63:0]      r_acc;
  logic [63:0]      w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_step_ovf;

  assign w_in_xfer  = bus.in_valid  && (r_state == S_ACCUM);
  assign w_out_xfer = bus.out_ready && (r_state == S_DONE);

  // Signed overflow of this step: both operands share a sign and the wrapped
  // result has the other sign.
  assign w_step_ovf = (r_acc[63] == bus.in_data[63]) && (bus.add_sum[63] != r_acc[63]);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // start is deliberately not looked at here.
        if (w_in_xfer) begin
          w_acc_nxt = bus.add_sum;
          w_cnt_nxt = r_cnt + 1'b1;
          w_ovf_nxt = r_ovf | w_step_ovf;
          if (r_cnt == LAST) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (w_out_xfer) begin
          if (bus.start) begin
            // Back-to-back burst: skip IDLE entirely.
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = S_ACCUM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_acc;
  assign bus.add_a     = r_acc;
  // Operand B is zero outside ACCUM so the adder output is just the accumulator.
  assign bus.add_b     = (r_state == S_ACCUM) ? bus.in_data : 64'd0;

  assign busy      = (r_state == S_ACCUM) || (r_state == S_DONE);
  assign ovf       = r_ovf;
  assign term_cnt  = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_acc64_sequencer.sv
// Testbench for acc64_sequencer. Four instances are built with burst lengths
// 32, 4, 2 and 1. Each instance has its own expected-sum queue and its own
// output monitor. The reference model sums terms in wide signed arithmetic
// and flags any partial sum that leaves the 64-bit signed range.
module tb_acc64_sequencer;
  localparam int NI = 4;

  function automatic int nt_of(input int i);
    case (i)
      0:       return 32;
      1:       return 4;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        start     [NI];
  logic        in_valid  [NI];
  logic [63:0] in_data   [NI];
  logic        out_ready [NI];
  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic [63:0] out_data  [NI];
  logic        busy      [NI];
  logic        ovf       [NI];
  logic [5:0]  term_cnt  [NI];
  logic [1:0]  dbg_state [NI];

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] tv [64];

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    acc64_sequencer_if bus();
    logic [64:0] exp_q[$];

    assign bus.start     = start[g];
    assign bus.in_valid  = in_valid[g];
    assign bus.in_data   = in_data[g];
    assign bus.out_ready = out_ready[g];
    assign bus.add_sum   = bus.add_a + bus.add_b;
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign out_data[g]   = bus.out_data;

    acc64_sequencer #(.N_TERMS(nt_of(g)), .CNT_W(6)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .bus       (bus.slave),
      .busy      (busy[g]),
      .ovf       (ovf[g]),
      .term_cnt  (term_cnt[g]),
      .dbg_state (dbg_state[g])
    );

    // scoreboard monitor
    always @(negedge clk) begin
      logic [64:0] e;
      if (!rst[g] && out_valid[g] && out_ready[g]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output inst%0d: got %h expected none", g, out_data[g]);
        end else begin
          e = exp_q.pop_front();
          check("out_data", g, out_data[g], e[63:0]);
          check("out_ovf", g, 64'(ovf[g]), 64'(e[64]));
          check("out_term_cnt", g, 64'(term_cnt[g]), 64'(nt_of(g)));
        end
      end
    end
  end

  // reference model: {sticky_ovf, wrapped_sum} of tv[0..n-1]
  function automatic logic [64:0] model(input int n);
    logic signed [64:0] w;
    logic [63:0] s;
    logic        o;
    s = 64'd0;
    o = 1'b0;
    for (int k = 0; k < n; k++) begin
      w = $signed({s[63], s}) + $signed({tv[k][63], tv[k]});
      if (w > 65'sh0_7FFF_FFFF_FFFF_FFFF || w < 65'sh1_8000_0000_0000_0000) o = 1'b1;
      s = w[63:0];
    end
    return {o, s};
  endfunction

  task automatic push_exp(input int i, input int n);
    logic [64:0] e;
    e = model(n);
    case (i)
      0:       g_inst[0].exp_q.push_back(e);
      1:       g_inst[1].exp_q.push_back(e);
      2:       g_inst[2].exp_q.push_back(e);
      default: g_inst[3].exp_q.push_back(e);
    endcase
  endtask

  function automatic int q_left();
    return g_inst[0].exp_q.size() + g_inst[1].exp_q.size() +
           g_inst[2].exp_q.size() + g_inst[3].exp_q.size();
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic send_terms(input int i, input int off, input int n, input bit gaps);
    int b;
    for (int k = off; k < off + n; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b0;
          tick();
        end
      end
      in_valid[i] = 1'b1;
      in_data[i]  = tv[k];
      b = 0;
      @(negedge clk);
      while (!in_ready[i] && b < 50) begin
        @(negedge clk);
        b++;
      end
      if (!in_ready[i]) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout inst%0d: got in_ready=0 expected 1", i);
        in_valid[i] = 1'b0;
        return;
      end
      tick();
    end
    in_valid[i] = 1'b0;
    in_data[i]  = {$urandom(), $urandom()};
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; in_valid[i] = 1'b0;
      in_data[i] = 64'd0; out_ready[i] = 1'b1;
    end
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      check("rst_in_ready", i, 64'(in_ready[i]), 64'd0);
      check("rst_out_valid", i, 64'(out_valid[i]), 64'd0);
      check("rst_busy", i, 64'(busy[i]), 64'd0);
      check("rst_term_cnt", i, 64'(term_cnt[i]), 64'd0);
      check("rst_out_data", i, out_data[i], 64'd0);
      rst[i] = 1'b0;
    end
    tick();

    // basic sum, 4 terms
    start_burst(1);
    check("start_term_cnt", 1, 64'(term_cnt[1]), 64'd0);
    check("start_in_ready", 1, 64'(in_ready[1]), 64'd1);
    tv[0] = 64'd10; tv[1] = -64'sd3; tv[2] = 64'd7; tv[3] = 64'd100;
    send_terms(1, 0, 4, 1'b0);
    push_exp(1, 4);
    check("basic_valid_latency", 1, 64'(out_valid[1]), 64'd1);
    tick();
    check("idle_out_data_kept", 1, out_data[1], 64'd114);
    check("idle_busy", 1, 64'(busy[1]), 64'd0);

    // reset mid-burst, then 32 ones
    for (int k = 0; k < 32; k++) tv[k] = 64'd1;
    start_burst(0);
    send_terms(0, 0, 5, 1'b0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("midrst_in_ready", 0, 64'(in_ready[0]), 64'd0);
    check("midrst_out_valid", 0, 64'(out_valid[0]), 64'd0);
    check("midrst_busy", 0, 64'(busy[0]), 64'd0);
    check("midrst_term_cnt", 0, 64'(term_cnt[0]), 64'd0);
    check("midrst_out_data", 0, out_data[0], 64'd0);
    start_burst(0);
    send_terms(0, 0, 32, 1'b1);
    push_exp(0, 32);
    tick();
    tick();

    // stalls and backpressure: terms 0..31, sum 496
    for (int k = 0; k < 32; k++) tv[k] = 64'(k);
    out_ready[0] = 1'b0;
    start_burst(0);
    send_terms(0, 0, 32, 1'b1);
    push_exp(0, 32);
    in_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", 0, 64'(out_valid[0]), 64'd1);
      check("stall_out_data", 0, out_data[0], 64'd496);
      check("stall_in_ready", 0, 64'(in_ready[0]), 64'd0);
      check("stall_term_cnt", 0, 64'(term_cnt[0]), 64'd32);
      tick();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    tick();

    // signed overflow, then cleared by the next start
    tv[0] = 64'h7FFF_FFFF_FFFF_FFFF; tv[1] = 64'd1;
    start_burst(2);
    send_terms(2, 0, 2, 1'b0);
    push_exp(2, 2);
    tick();
    tick();
    check("ovf_kept_idle", 2, 64'(ovf[2]), 64'd1);
    check("ovf_sum", 2, out_data[2], 64'h8000_0000_0000_0000);
    start_burst(2);
    check("ovf_cleared", 2, 64'(ovf[2]), 64'd0);
    tv[0] = 64'd5; tv[1] = 64'd6;
    send_terms(2, 0, 2, 1'b0);
    push_exp(2, 2);
    tick();
    tick();

    // back-to-back bursts
    for (int k = 0; k < 4; k++) tv[k] = {$urandom(), $urandom()};
    out_ready[1] = 1'b0;
    start_burst(1);
    send_terms(1, 0, 4, 1'b0);
    push_exp(1, 4);
    out_ready[1] = 1'b1;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("b2b_state_accum", 1, 64'(dbg_state[1]), 64'd1);
    check("b2b_term_cnt", 1, 64'(term_cnt[1]), 64'd0);
    check("b2b_acc", 1, out_data[1], 64'd0);
    check("b2b_ovf", 1, 64'(ovf[1]), 64'd0);
    for (int k = 0; k < 4; k++) tv[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    send_terms(1, 0, 4, 1'b0);
    push_exp(1, 4);
    tick();
    check("b2b_sum_minus4", 1, out_data[1], 64'hFFFF_FFFF_FFFF_FFFC);
    tick();

    // start ignored in ACCUM
    tv[0] = 64'd1; tv[1] = 64'd2; tv[2] = 64'd3; tv[3] = 64'd4;
    start_burst(1);
    send_terms(1, 0, 2, 1'b0);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("ign_start_cnt", 1, 64'(term_cnt[1]), 64'd2);
    check("ign_start_state", 1, 64'(dbg_state[1]), 64'd1);
    send_terms(1, 2, 2, 1'b0);
    push_exp(1, 4);
    tick();
    check("ign_start_sum", 1, out_data[1], 64'd10);
    tick();

    // single-term burst
    tv[0] = {$urandom(), $urandom()};
    start_burst(3);
    send_terms(3, 0, 1, 1'b0);
    push_exp(3, 1);
    check("n1_valid", 3, 64'(out_valid[3]), 64'd1);
    tick();
    tick();

    // randomized bursts with random backpressure
    for (int r = 0; r < 6; r++) begin
      for (int i = 1; i < NI; i++) begin
        for (int k = 0; k < nt_of(i); k++) begin
          tv[k] = {$urandom(), $urandom()};
          if ($urandom_range(0, 3) == 0) tv[k] = {1'b0, 63'h7FFF_FFFF_FFFF_FFF0} + 64'($urandom_range(0, 15));
        end
        out_ready[i] = ($urandom_range(0, 1) == 1);
        start_burst(i);
        send_terms(i, 0, nt_of(i), 1'b1);
        push_exp(i, nt_of(i));
        repeat ($urandom_range(0, 3)) tick();
        out_ready[i] = 1'b1;
        tick();
        tick();
      end
    end

    repeat (4) tick();
    check("queues_drained", 0, 64'(q_left()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
